// File: rtl/arbiter_1_to_n_response_credit.sv
// Credit-flow-controlled 1-to-N memory response dispatcher with all-or-nothing multicast.
// Optional statistics counters are enabled by defining ARBITER_RESPONSE_STATS_EN.
package arbiter_1_to_n_response_credit_pkg;

    typedef struct packed {
        logic [15:0] id_cu;
        logic [15:0] id_bundle;
        logic [15:0] id_lane;
        logic [15:0] id_engine;
        logic [15:0] id_module;
    } PacketSource;

    typedef struct packed {
        PacketSource packet_source;
        logic [63:0] address;
        logic [31:0] data;
    } MemoryPacketPayload;

    typedef struct packed {
        logic               valid;
        MemoryPacketPayload payload;
    } MemoryPacket;

    typedef struct packed {
        logic full;
        logic empty;
        logic valid;
        logic prog_full;
        logic wr_rst_busy;
        logic rd_rst_busy;
    } FIFOStateSignalsOutput;

endpackage

module arbiter_1_to_n_response_credit
    import arbiter_1_to_n_response_credit_pkg::*;
#(
    parameter int ID_LEVEL            = 1,
    parameter int NUM_MEMORY_RECEIVER = 2,
    parameter int RECEIVER_CREDITS    = 4,
    parameter int FIFO_ARBITER_DEPTH  = 16,
    parameter int PROG_THRESH         = FIFO_ARBITER_DEPTH - 4
) (
    input  logic                           ap_clk,
    input  logic                           areset,
    input  MemoryPacket                    response_in,
    input  logic [NUM_MEMORY_RECEIVER-1:0] credit_return_in,
    output FIFOStateSignalsOutput          fifo_response_signals_out,
    output MemoryPacket                    response_out [NUM_MEMORY_RECEIVER],
    output logic                           fifo_setup_signal,
    output logic                           credit_overflow,
    output logic [15:0]                    drop_count,
    output logic [31:0]                    stats_dispatch [NUM_MEMORY_RECEIVER],
    output logic [31:0]                    stats_stall
);

    localparam int CW = $clog2(RECEIVER_CREDITS + 1);
    localparam int AW = $clog2(FIFO_ARBITER_DEPTH);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(RECEIVER_CREDITS);
    localparam logic [AW:0]   FIFO_FULL_LEVEL = (AW + 1)'(FIFO_ARBITER_DEPTH);
    localparam logic [AW:0]   FIFO_PROG_LEVEL = (AW + 1)'(PROG_THRESH);

    typedef enum logic [1:0] {S_SETUP, S_RUN, S_STALL} state_t;

    // ID_LEVEL 5 broadcasts; unknown levels fall back to the CU field.
    function automatic logic [NUM_MEMORY_RECEIVER-1:0] route_mask(input PacketSource src);
        logic [15:0] field;
        case (ID_LEVEL)
            1:       field = src.id_bundle;
            2:       field = src.id_lane;
            3:       field = src.id_engine;
            4:       field = src.id_module;
            5:       field = '1;
            default: field = src.id_cu;
        endcase
        return NUM_MEMORY_RECEIVER'(field);
    endfunction

    state_t                         state, state_next;
    logic [1:0]                     setup_cnt;
    MemoryPacket                    in_reg;
    logic [NUM_MEMORY_RECEIVER-1:0] in_mask;
    MemoryPacketPayload             mem [FIFO_ARBITER_DEPTH];
    logic [AW-1:0]                  wr_ptr, rd_ptr;
    logic [AW:0]                    count;
    logic                           fifo_full, head_valid;
    MemoryPacketPayload             head;
    logic [NUM_MEMORY_RECEIVER-1:0] head_mask;
    logic [CW-1:0]                  credit [NUM_MEMORY_RECEIVER];
    logic                           credits_ok, dispatch, do_write, do_drop;

    assign in_mask    = route_mask(in_reg.payload.packet_source);
    assign fifo_full  = (count == FIFO_FULL_LEVEL);
    assign head_valid = (count != '0);
    assign head       = mem[rd_ptr];
    assign head_mask  = route_mask(head.packet_source);
    assign do_write   = in_reg.valid && (in_mask != '0) && (!fifo_full || dispatch);
    assign do_drop    = in_reg.valid && !do_write;

    // Valids seen during initialisation are discarded before they reach the FIFO.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            in_reg <= '0;
        end else begin
            in_reg.valid   <= response_in.valid && (state != S_SETUP);
            in_reg.payload <= response_in.payload;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (do_write) begin
            mem[wr_ptr] <= in_reg.payload;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (dispatch) rd_ptr <= rd_ptr + 1'b1;
            case ({do_write, dispatch})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        credits_ok = 1'b1;
        for (int i = 0; i < NUM_MEMORY_RECEIVER; i++) begin
            if (head_mask[i] && (credit[i] == '0)) credits_ok = 1'b0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state     <= S_SETUP;
            setup_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == S_SETUP) setup_cnt <= setup_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        dispatch   = 1'b0;
        case (state)
            S_SETUP: begin
                if (setup_cnt == 2'd3) state_next = S_RUN;
            end
            S_RUN: begin
                if (head_valid) begin
                    if (credits_ok) dispatch = 1'b1;
                    else            state_next = S_STALL;
                end
            end
            S_STALL: begin
                if (head_valid && credits_ok) begin
                    dispatch   = 1'b1;
                    state_next = S_RUN;
                end
            end
            default: state_next = S_SETUP;
        endcase
    end

    // A take and a give in the same cycle cancel, so a full counter is not an overflow then.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            for (int i = 0; i < NUM_MEMORY_RECEIVER; i++) credit[i] <= CREDIT_MAX;
            credit_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_MEMORY_RECEIVER; i++) begin
                if (dispatch && head_mask[i] && !credit_return_in[i]) begin
                    credit[i] <= credit[i] - 1'b1;
                end else if (credit_return_in[i] && !(dispatch && head_mask[i])) begin
                    if (credit[i] == CREDIT_MAX) credit_overflow <= 1'b1;
                    else                         credit[i] <= credit[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            for (int i = 0; i < NUM_MEMORY_RECEIVER; i++) response_out[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_MEMORY_RECEIVER; i++) begin
                response_out[i].valid   <= dispatch && head_mask[i];
                response_out[i].payload <= head;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            fifo_response_signals_out       <= '0;
            fifo_response_signals_out.empty <= 1'b1;
            fifo_setup_signal               <= 1'b1;
            drop_count                      <= '0;
        end else begin
            fifo_response_signals_out.full        <= fifo_full;
            fifo_response_signals_out.empty       <= !head_valid;
            fifo_response_signals_out.valid       <= head_valid;
            fifo_response_signals_out.prog_full   <= (count >= FIFO_PROG_LEVEL);
            fifo_response_signals_out.wr_rst_busy <= 1'b0;
            fifo_response_signals_out.rd_rst_busy <= 1'b0;
            fifo_setup_signal                     <= (state == S_SETUP);
            if (do_drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
        end
    end

`ifdef ARBITER_RESPONSE_STATS_EN
    // Stall cycles exclude the cycle in which the stalled head finally dispatches.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            stats_stall <= '0;
            for (int i = 0; i < NUM_MEMORY_RECEIVER; i++) stats_dispatch[i] <= '0;
        end else begin
            if ((state == S_STALL) && !dispatch) stats_stall <= stats_stall + 32'd1;
            for (int i = 0; i < NUM_MEMORY_RECEIVER; i++) begin
                if (dispatch && head_mask[i]) stats_dispatch[i] <= stats_dispatch[i] + 32'd1;
            end
        end
    end
`else
    assign stats_stall = '0;
    for (genvar g = 0; g < NUM_MEMORY_RECEIVER; g++) begin : g_no_stats
        assign stats_dispatch[g] = '0;
    end
`endif

endmodule

// File: doc/arbiter_1_to_n_response_credit.md
# arbiter_1_to_N_response_credit

Credit-flow-controlled successor of the 1-to-N memory response demultiplexer: buffers MemoryPacket responses from one memory/cache port and dispatches each to one or more of NUM_MEMORY_RECEIVER receivers, selected by the packet_source ID field at ID_LEVEL. A per-receiver credit counter replaces rd_en mask matching, so receivers never overflow. Multicast is all-or-nothing, and packets with an empty route are dropped and counted. Sits between a memory channel's response path and the bundle/lane/engine response FIFOs.

## Interface
- ID_LEVEL, 1: route field; 0 id_cu, 1 id_bundle, 2 id_lane, 3 id_engine, 4 id_module, 5 broadcast to all; other values behave as 0
- NUM_MEMORY_RECEIVER, 2: receiver count N, 1..16
- RECEIVER_CREDITS, 4: initial and maximum credits per receiver, 1..64
- FIFO_ARBITER_DEPTH, 16: internal FIFO entries, power of two ≥4
- PROG_THRESH, FIFO_ARBITER_DEPTH-4: occupancy at which prog_full asserts
- ap_clk  in  1  clock
- areset  in  1  synchronous, active-high reset
- response_in  in  MemoryPacket  incoming response; accepted when valid
- credit_return_in  in  N  bit i = receiver i freed one slot this cycle
- fifo_response_signals_out  out  FIFOStateSignalsOutput  registered internal FIFO state; prog_full is upstream backpressure
- response_out  out  MemoryPacket[N]  per-receiver response, registered
- fifo_setup_signal  out  1  high while the block is initialising
- credit_overflow  out  1  sticky: a credit was returned to a full counter
- drop_count  out  16  packets discarded for an empty route, saturating
- stats_dispatch  out  32×N  per-receiver dispatch count, zero when stats disabled
- stats_stall  out  32  head-blocked cycles, zero when stats disabled

## Operation
- Input stage: response_in is registered. The route mask M = selected ID field bits [N-1:0], or all ones at ID_LEVEL 5.
  - M≠0: write to the FIFO.
  - M=0: not written; drop_count +1, saturating at 0xFFFF.
- FIFO: register-based, first-word-fall-through. A written entry is visible at the head the next cycle. Writing while full is discarded and also increments drop_count. Upstream must respect prog_full.
- Credits: credit[i] is $clog2(RECEIVER_CREDITS+1) bits and resets to RECEIVER_CREDITS.
  - Dispatch to i: credit[i] −1.
  - credit_return_in[i]: credit[i] +1.
  - Both in the same cycle: credit[i] unchanged.
  - Return at maximum with no dispatch: the counter holds and credit_overflow is set until reset.
- FSM:
  - S_SETUP: entered on reset. Held for 4 cycles; fifo_setup_signal=1 and no writes or dispatch. Input valids arriving during S_SETUP are discarded and not counted. Then goes to S_RUN.
  - S_RUN: when the head is valid and credit[i]>0 for every i in M, pop the head and dispatch. If the head is valid and any required credit is 0, go to S_STALL.
  - S_STALL: no pop. stats_stall +1 per cycle. Return to S_RUN, and dispatch in that same cycle, once all required credits are >0 (returns counted as they arrive).
- Dispatch: response_out[i].valid = M[i] for exactly one cycle. The payload is copied to all outputs. Partial multicast never occurs.
- Reset mid-operation: FIFO contents, credits, counters and the sticky flag are cleared or reinitialised the next cycle; in-flight packets are lost.

## Timing
- Reset values:
  - response_out[*].valid=0
  - fifo_setup_signal=1
  - fifo_response_signals_out: empty=1; full, prog_full, valid, wr_rst_busy, rd_rst_busy=0
  - credit_overflow=0, drop_count=0, all stats=0
- Latency: response_in.valid at cycle T, FIFO empty, credits available → response_out valid at T+3 (T+1 registered and written, T+2 head and dispatch decision, T+3 output register).
- Throughput: one dispatch per cycle while credits last.
- A credit returned in cycle T can enable a dispatch decision in T+1.
- fifo_response_signals_out and fifo_setup_signal lag internal state by one cycle.
- Simultaneous FIFO write and pop when full: the pop frees the slot, so the write is accepted.

## Configuration
- ARBITER_RESPONSE_STATS_EN
  - Defined: stats_dispatch[i] increments on each dispatch to i, and stats_stall counts S_STALL cycles. Both are 32-bit wrapping counters, cleared by reset.
  - Undefined: both outputs are tied to 0 and no counter logic is synthesised.
  - Functional behaviour is otherwise identical.

## Test plan
- N=4, ID_LEVEL=1, one packet id_bundle=4'b0100 after setup → response_out[2].valid one cycle at T+3, others 0; credit[2]=3.
- Multicast id_bundle=4'b0011 with credit[1]=0 → stalls until credit_return_in[1] pulses; then out[0] and out[1] fire together; stats_stall equals the blocked cycles.
- Five packets to receiver 0 with no returns, RECEIVER_CREDITS=4 → exactly 4 dispatched, fifth held; a single return releases it.
- Packet with id_bundle=0 → no output, drop_count=1. ID_LEVEL=5 with the same packet → all outputs fire.
- Return credit to a full counter → credit_overflow=1 and stays 1; simultaneous dispatch plus return leaves the credit unchanged.
- areset asserted with 6 queued packets → next cycle all outputs at reset values, fifo_setup_signal high for 4 cycles, no stale dispatch afterwards.
